pipe_field: RTL
===============

# pipe_field

Scrolling obstacle field and collision detector for the Flappy Bird LED game; the counterpart to `bird`. It consumes the bird's one-hot row vector, produces the `col` collision pulse and the pipe pattern for the LED matrix, and keeps the score. Pipes enter at the rightmost column and shift left at a rate divided down from `tick`. Each pipe's gap row comes from an LFSR.

## Interface
- ROWS, 8: LED rows; bird vector width; must be a power of 2.
- COLS, 8: LED columns in the field.
- BIRD_COL, 2: column index the bird occupies; 1 ≤ BIRD_COL < COLS.
- SCROLL_DIV, 8: `tick` pulses per scroll step; ≥ 1.
- GAP, 3: open rows per pipe; 1 ≤ GAP < ROWS.
- SPACING, 4: scroll steps between pipe emissions; ≥ 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- tick  in  1  game-rate enable, one-cycle pulse.
- start  in  1  player key; level, sampled each clock.
- died  in  1  bird left the screen.
- bird  in  ROWS  bird row vector, one-hot, bit r = row r.
- col  out  1  collision pulse to `bird`; registered.
- grid  out  COLS*ROWS  field; bit c*ROWS+r = column c, row r; 1 = pipe lit.
- score  out  8  pipes passed, saturating at 255.
- scored  out  1  one-cycle pulse on each score increment.

## Operation
- States:
  - IDLE: entered only from reset.
  - PLAY
  - OVER
- Transitions:
  - IDLE→PLAY when `start`=1.
  - PLAY→OVER on overlap or `died`.
  - OVER→PLAY when `start`=1. That transition clears the field, the divider, the spacing counter and `score`. It does not reset the LFSR.
- Overlap is `|(bird & column[BIRD_COL])`, using the registered column. PLAY only.
- `col` is registered. It is 1 for exactly the one cycle after a PLAY→OVER transition caused by overlap.
  - `col` stays 0 on a `died`-caused transition.
  - `col` is never held high. A combinational `col` would loop through `bird`.
- Scroll step: PLAY and `tick`=1 and divider = SCROLL_DIV-1. The divider then resets to 0; otherwise it increments on `tick`.
- On a step:
  - Column c takes column c+1 for c < COLS-1. Column 0 is discarded.
  - Column COLS-1 takes the new column.
- New column:
  - If the spacing counter = 0, emit a pipe and reload the counter to SPACING-1.
  - Otherwise emit all zeros and decrement the counter.
- Pipe column: all ones except rows base..base+GAP-1.
  - r = lfsr[log2(ROWS)-1:0].
  - base = r if r ≤ ROWS-GAP, else r-(ROWS-GAP+1).
- LFSR: 8 bits, seed 8'hA5.
  - Advances only on a pipe emission, after the current value is used.
  - Update: lfsr ← {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Score: on a step where column[BIRD_COL] (before the shift) is nonzero, `score` increments (saturating) and `scored` pulses on the following cycle.
- In IDLE and OVER, `tick` is ignored and grid/score hold. `start` in PLAY is ignored.
- Collision priority: a cycle that is both overlap and a scroll step goes to OVER with no shift, no score and no LFSR advance. Same rule for `died`.
- Reset values:
  - IDLE.
  - grid = 0, score = 0, col = 0, scored = 0.
  - Divider = 0, spacing counter = 0 (so the first step emits a pipe).
  - lfsr = 8'hA5.
- Reset mid-game returns to IDLE with every reset value above, including the LFSR.

## Timing
- `col` rises one clock after the edge on which overlap is first evaluated true. Overlap is evaluated on the registered grid, i.e. one clock after the step that moved the pipe into BIRD_COL.
- `grid`, `score` and `scored` are all registered. `grid` updates on the step edge. `scored` is high one cycle, aligned with the new `score` value.
- A pipe emitted at step k is in column COLS-1-(j-k) after step j. It reaches BIRD_COL at step k+(COLS-1-BIRD_COL) and scores on the next step.
- Latency start→PLAY: 1 clock.

## Test plan
Parameters: ROWS=8, COLS=8, BIRD_COL=2, SCROLL_DIV=2, GAP=3, SPACING=4.
- Reset held 2 cycles → grid=0, score=0, col=0, scored=0; `tick` pulses in IDLE leave grid=0.
- `start` 1 cycle, then 2 ticks → column 7 = 8'b00011111 (r=5, gap rows 5–7). Then 8 more ticks (4 steps) → column 7 = 8'b11100011 (lfsr 8'h4A, gap rows 2–4) and the first pipe is in column 3.
- bird=8'b00100000 held, ticks continue → first pipe in column 2 after step 6, no `col`. Step 7 → score=1, `scored` high 1 cycle.
- bird=8'b00000001 → after step 6, `col`=1 for exactly 1 cycle, state OVER. Grid frozen under 20 further ticks; `col` stays 0.
- In OVER, `start` → grid=0, score=0, next pipe uses the continued LFSR value (not 8'hA5). `died`=1 in PLAY → OVER with `col`=0.
- Overlap on the same cycle as a step edge → no shift, score unchanged, `col` pulses. `reset` asserted in PLAY → all reset values next cycle.

Source files
------------

// File: rtl/pipe_field_if.sv
// Signal bundle between pipe_field and its game-side peer (bird logic / LED driver).
// The master drives the game inputs; pipe_field is the slave and drives field outputs.
interface pipe_field_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  logic                 tick;
  logic                 start;
  logic                 died;
  logic [ROWS-1:0]      bird;
  logic                 col;
  logic [COLS*ROWS-1:0] grid;
  logic [7:0]           score;
  logic                 scored;

  modport master (
    output tick, start, died, bird,
    input  col, grid, score, scored
  );

  modport slave (
    input  tick, start, died, bird,
    output col, grid, score, scored
  );
endinterface

// File: rtl/pipe_field.sv
// Scrolling pipe field for the LED Flappy Bird game: shifts pipes left, detects
// collision with the bird's row vector and counts pipes passed.
module pipe_field #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int BIRD_COL   = 2,
  parameter int SCROLL_DIV = 8,
  parameter int GAP        = 3,
  parameter int SPACING    = 4
) (
  input logic         clk,
  input logic         reset,
  pipe_field_if.slave bus
);

  localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int SW = $clog2(SPACING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t               state_r;
  logic [COLS*ROWS-1:0] grid_r;
  logic [DW-1:0]        div_r;
  logic [SW-1:0]        space_r;
  logic [7:0]           lfsr_r;
  logic [7:0]           score_r;
  logic                 col_r;
  logic                 scored_r;

  logic [ROWS-1:0]      bird_col_s;
  logic [ROWS-1:0]      new_col_s;
  logic                 overlap_s;
  logic                 step_s;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Gap rows that would run off the top wrap back to start near row 0.
  function automatic logic [ROWS-1:0] pipe_col(input logic [7:0] v);
    int              r;
    int              base;
    logic [ROWS-1:0] m;
    r    = int'(v) % ROWS;
    base = (r <= ROWS - GAP) ? r : r - (ROWS - GAP + 1);
    for (int i = 0; i < ROWS; i++) begin
      m[i] = (i < base) || (i >= base + GAP);
    end
    return m;
  endfunction

  assign bird_col_s = grid_r[BIRD_COL*ROWS +: ROWS];
  assign overlap_s  = |(bus.bird & bird_col_s);
  assign step_s     = bus.tick && (div_r == DW'(SCROLL_DIV - 1));

  // Column entering at the right edge: a pipe when spacing has run out, else empty.
  always_comb begin
    new_col_s = '0;
    if (space_r == '0) begin
      new_col_s = pipe_col(lfsr_r);
    end else begin
      new_col_s = '0;
    end
  end

  // Game FSM with field, divider, spacing, LFSR and score state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      grid_r   <= '0;
      div_r    <= '0;
      space_r  <= '0;
      lfsr_r   <= 8'hA5;
      score_r  <= 8'd0;
      col_r    <= 1'b0;
      scored_r <= 1'b0;
    end else begin
      col_r    <= 1'b0;
      scored_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r <= PLAY;
          end
        end
        PLAY: begin
          // Collision wins over a coincident scroll step: the field freezes as-is.
          if (overlap_s || bus.died) begin
            state_r <= OVER;
            col_r   <= overlap_s;
          end else if (step_s) begin
            div_r  <= '0;
            grid_r <= {new_col_s, grid_r[COLS*ROWS-1:ROWS]};
            if (space_r == '0) begin
              space_r <= SW'(SPACING - 1);
              lfsr_r  <= lfsr_next(lfsr_r);
            end else begin
              space_r <= space_r - SW'(1);
            end
            if ((|bird_col_s) && (score_r != 8'd255)) begin
              score_r  <= score_r + 8'd1;
              scored_r <= 1'b1;
            end
          end else if (bus.tick) begin
            div_r <= div_r + DW'(1);
          end
        end
        OVER: begin
          // Restart keeps the LFSR running so a new game sees fresh gaps.
          if (bus.start) begin
            state_r <= PLAY;
            grid_r  <= '0;
            div_r   <= '0;
            space_r <= '0;
            score_r <= 8'd0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.col    = col_r;
  assign bus.grid   = grid_r;
  assign bus.score  = score_r;
  assign bus.scored = scored_r;

endmodule
